// File: rtl/tpu_cmd_sequencer.sv
//==============================================================================
// Module   : tpu_cmd_sequencer
// Brief    : Queues TPU matrix-op descriptors, launches them one at a time,
//            recovers from TPU error/timeout and returns tagged completions.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tpu_cmd_sequencer #(
    parameter int          DEPTH   = 4,
    parameter int          TAG_W   = 8,
    parameter logic [31:0] TIMEOUT = 32'd1000000
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [7:0]                 cmd_operation,
    input  logic [1:0]                 cmd_data_type,
    input  logic [7:0]                 cmd_m,
    input  logic [7:0]                 cmd_n,
    input  logic [7:0]                 cmd_k,
    input  logic [TAG_W-1:0]           cmd_tag,
    input  logic                       flush,

    output logic                       tpu_enable,
    output logic                       tpu_start,
    output logic [7:0]                 tpu_operation,
    output logic [1:0]                 tpu_data_type,
    output logic [7:0]                 tpu_matrix_size_m,
    output logic [7:0]                 tpu_matrix_size_n,
    output logic [7:0]                 tpu_matrix_size_k,
    input  logic                       tpu_done,
    input  logic                       tpu_busy,
    input  logic                       tpu_error,

    output logic                       cpl_valid,
    input  logic                       cpl_ready,
    output logic [TAG_W-1:0]           cpl_tag,
    output logic [1:0]                 cpl_status,
    output logic [31:0]                cpl_cycles,
    output logic [$clog2(DEPTH):0]     queue_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = TAG_W + 34;

    localparam logic [CW-1:0] c_DEPTH      = CW'(DEPTH);
    localparam logic [31:0]   c_TIMEOUT_M1 = TIMEOUT - 32'd1;

    localparam logic [1:0] c_ST_OK      = 2'b00;
    localparam logic [1:0] c_ST_ERROR   = 2'b01;
    localparam logic [1:0] c_ST_REJECT  = 2'b10;
    localparam logic [1:0] c_ST_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LAUNCH   = 3'd1,
        ST_RUN      = 3'd2,
        ST_RECOVER  = 3'd3,
        ST_COMPLETE = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [EW-1:0]     r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    logic [TAG_W-1:0]  w_h_tag;
    logic [7:0]        w_h_op;
    logic [1:0]        w_h_dt;
    logic [7:0]        w_h_m;
    logic [7:0]        w_h_n;
    logic [7:0]        w_h_k;
    logic              w_h_zero;

    logic [7:0]        r_op;
    logic [1:0]        r_dt;
    logic [7:0]        r_m;
    logic [7:0]        r_n;
    logic [7:0]        r_k;

    logic [TAG_W-1:0]  r_cpl_tag;
    logic [1:0]        r_cpl_status;
    logic [31:0]       r_cpl_cycles;
    logic [31:0]       r_cycle_cnt;
    logic [31:0]       w_cnt_inc;
    logic              w_timeout;
    logic              w_run_exit;
    logic [1:0]        w_exit_status;

    //--------------------------------------------------------------------------
    // Command FIFO
    //--------------------------------------------------------------------------
    assign w_full      = (r_count == c_DEPTH);
    assign w_empty     = (r_count == '0);
    assign cmd_ready   = !w_full && !flush;
    assign w_push      = cmd_valid && cmd_ready;
    assign w_pop       = (r_state == ST_IDLE) && !w_empty && !tpu_busy;
    assign queue_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_tag, cmd_operation, cmd_data_type, cmd_m, cmd_n, cmd_k};
        end
    end

    // A flush never coincides with a push (ready is low), so the write pointer
    // is stable and the read pointer can simply catch up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    assign {w_h_tag, w_h_op, w_h_dt, w_h_m, w_h_n, w_h_k} = r_mem[r_rd_ptr];
    assign w_h_zero = (w_h_m == 8'd0) || (w_h_n == 8'd0) || (w_h_k == 8'd0);

    //--------------------------------------------------------------------------
    // Sequencer FSM
    //--------------------------------------------------------------------------
    assign w_cnt_inc = (r_cycle_cnt == 32'hFFFF_FFFF) ? r_cycle_cnt : r_cycle_cnt + 32'd1;
    assign w_timeout = (TIMEOUT != 32'd0) && (r_cycle_cnt == c_TIMEOUT_M1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        tpu_enable    = 1'b0;
        tpu_start     = 1'b0;
        cpl_valid     = 1'b0;
        w_run_exit    = 1'b0;
        w_exit_status = c_ST_OK;
        case (r_state)
            ST_IDLE: begin
                if (w_pop) begin
                    w_state_nxt = w_h_zero ? ST_COMPLETE : ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                tpu_enable  = 1'b1;
                tpu_start   = 1'b1;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                tpu_enable = 1'b1;
                // done outranks error, which outranks the timeout
                if (tpu_done) begin
                    w_run_exit    = 1'b1;
                    w_exit_status = c_ST_OK;
                    w_state_nxt   = ST_COMPLETE;
                end else if (tpu_error) begin
                    w_run_exit    = 1'b1;
                    w_exit_status = c_ST_ERROR;
                    w_state_nxt   = ST_RECOVER;
                end else if (w_timeout) begin
                    w_run_exit    = 1'b1;
                    w_exit_status = c_ST_TIMEOUT;
                    w_state_nxt   = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                if (!tpu_busy && !tpu_error) begin
                    w_state_nxt = ST_COMPLETE;
                end
            end
            ST_COMPLETE: begin
                cpl_valid = 1'b1;
                if (cpl_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Job configuration, cycle counter and completion record
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op         <= '0;
            r_dt         <= '0;
            r_m          <= '0;
            r_n          <= '0;
            r_k          <= '0;
            r_cpl_tag    <= '0;
            r_cpl_status <= '0;
            r_cpl_cycles <= '0;
            r_cycle_cnt  <= '0;
        end else begin
            if (w_pop) begin
                r_op      <= w_h_op;
                r_dt      <= w_h_dt;
                r_m       <= w_h_m;
                r_n       <= w_h_n;
                r_k       <= w_h_k;
                r_cpl_tag <= w_h_tag;
                if (w_h_zero) begin
                    r_cpl_status <= c_ST_REJECT;
                    r_cpl_cycles <= '0;
                end
            end
            if (r_state == ST_LAUNCH) begin
                r_cycle_cnt <= '0;
            end else if (r_state == ST_RUN) begin
                r_cycle_cnt <= w_cnt_inc;
            end
            if (w_run_exit) begin
                r_cpl_status <= w_exit_status;
                r_cpl_cycles <= w_cnt_inc;
            end
        end
    end

    assign tpu_operation     = r_op;
    assign tpu_data_type     = r_dt;
    assign tpu_matrix_size_m = r_m;
    assign tpu_matrix_size_n = r_n;
    assign tpu_matrix_size_k = r_k;
    assign cpl_tag           = r_cpl_tag;
    assign cpl_status        = r_cpl_status;
    assign cpl_cycles        = r_cpl_cycles;

endmodule

`default_nettype wire

// File: tb/tb_tpu_cmd_sequencer.sv
//==============================================================================
// Module   : tb_tpu_cmd_sequencer
// Brief    : Scoreboard bench with a behavioural TPU and queue model.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_tpu_cmd_sequencer;

    localparam int          DEPTH   = 4;
    localparam int          TAG_W   = 8;
    localparam logic [31:0] TIMEOUT = 32'd50;
    localparam int          CW      = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid, cmd_ready, flush;
    logic [7:0]       cmd_operation, cmd_m, cmd_n, cmd_k;
    logic [1:0]       cmd_data_type;
    logic [TAG_W-1:0] cmd_tag;
    logic             tpu_enable, tpu_start, tpu_done, tpu_busy, tpu_error;
    logic [7:0]       tpu_operation, tpu_matrix_size_m, tpu_matrix_size_n, tpu_matrix_size_k;
    logic [1:0]       tpu_data_type;
    logic             cpl_valid, cpl_ready;
    logic [TAG_W-1:0] cpl_tag;
    logic [1:0]       cpl_status;
    logic [31:0]      cpl_cycles;
    logic [CW-1:0]    queue_count;

    tpu_cmd_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_operation(cmd_operation),
        .cmd_data_type(cmd_data_type), .cmd_m(cmd_m), .cmd_n(cmd_n), .cmd_k(cmd_k),
        .cmd_tag(cmd_tag), .flush(flush),
        .tpu_enable(tpu_enable), .tpu_start(tpu_start), .tpu_operation(tpu_operation),
        .tpu_data_type(tpu_data_type), .tpu_matrix_size_m(tpu_matrix_size_m),
        .tpu_matrix_size_n(tpu_matrix_size_n), .tpu_matrix_size_k(tpu_matrix_size_k),
        .tpu_done(tpu_done), .tpu_busy(tpu_busy), .tpu_error(tpu_error),
        .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_tag(cpl_tag),
        .cpl_status(cpl_status), .cpl_cycles(cpl_cycles), .queue_count(queue_count)
    );

    always #5 clk = ~clk;

    // kind: 0 = done after len RUN cycles, 1 = error after len, 2 = never finishes
    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [7:0]       op;
        logic [1:0]       dt;
        logic [7:0]       m, n, k;
        int               kind;
        int               len;
    } desc_t;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [1:0]       st;
        logic [31:0]      cyc;
    } cpl_t;

    desc_t mq[$];
    desc_t plan_q[$];
    cpl_t  exp_q[$];

    int  checks = 0;
    int  errors = 0;
    bit  model_en = 0;
    bit  in_flight = 0;
    bit  rej_pending = 0;
    int  wd = 0;
    int  stim_kind = 0;
    int  stim_len = 1;
    int  rdy_mode = 0;
    int  next_tag = 16;

    desc_t cur;
    bit    t_act = 0;
    bit    t_rel = 0;
    int    t_k = 0;
    int    t_rel_cnt = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // TPU behaviour, queue/occupancy model and per-cycle observation checks
    always @(negedge clk) begin
        bit    pop, accept, hs;
        desc_t d;
        cpl_t  c;
        if (!model_en) begin
            tpu_done  = 1'b0;
            tpu_busy  = 1'b0;
            tpu_error = 1'b0;
            t_act     = 0;
            t_rel     = 0;
        end else begin
            check("queue_count", 64'(queue_count), 64'(mq.size()));
            check("cmd_ready", 64'(cmd_ready), 64'((mq.size() < DEPTH) && !flush));
            if (!in_flight) check("enable_without_job", 64'(tpu_enable), 64'(0));
            if (rej_pending) begin
                check("reject_cpl_next_cycle", 64'(cpl_valid), 64'(1));
                rej_pending = 0;
            end

            tpu_done = 1'b0;
            if (tpu_start) begin
                if (plan_q.size() == 0) begin
                    check("unexpected_start", 64'(tpu_start), 64'(0));
                end else begin
                    cur = plan_q.pop_front();
                    check("cfg_op", 64'(tpu_operation), 64'(cur.op));
                    check("cfg_dt", 64'(tpu_data_type), 64'(cur.dt));
                    check("cfg_mnk", {40'd0, tpu_matrix_size_m, tpu_matrix_size_n, tpu_matrix_size_k},
                          {40'd0, cur.m, cur.n, cur.k});
                    t_act     = 1;
                    t_k       = 0;
                    tpu_busy  = 1'b1;
                    tpu_error = 1'b0;
                end
            end else if (t_act) begin
                t_k++;
                if (cur.kind == 0 && t_k == cur.len) begin
                    tpu_done = 1'b1;
                    t_act    = 0;
                end else if (cur.kind == 1 && t_k == cur.len) begin
                    tpu_error = 1'b1;
                    t_act     = 0;
                    t_rel     = 1;
                    t_rel_cnt = $urandom_range(0, 3);
                end else if (cur.kind == 2 && !tpu_enable) begin
                    t_act     = 0;
                    t_rel     = 1;
                    t_rel_cnt = $urandom_range(0, 3);
                end
            end else if (t_rel) begin
                if (!tpu_enable) begin
                    if (t_rel_cnt == 0) begin
                        tpu_error = 1'b0;
                        tpu_busy  = 1'b0;
                        t_rel     = 0;
                    end else begin
                        t_rel_cnt--;
                    end
                end
            end else begin
                tpu_busy = 1'b0;
            end

            hs     = cpl_valid && cpl_ready;
            pop    = !in_flight && (mq.size() > 0) && !tpu_busy;
            accept = cmd_valid && (mq.size() < DEPTH) && !flush;
            if (pop) begin
                d     = mq.pop_front();
                c.tag = d.tag;
                if (d.m == 0 || d.n == 0 || d.k == 0) begin
                    c.st = 2'b10; c.cyc = 32'd0;
                    rej_pending = 1;
                end else begin
                    plan_q.push_back(d);
                    case (d.kind)
                        0:       begin c.st = 2'b00; c.cyc = 32'(d.len); end
                        1:       begin c.st = 2'b01; c.cyc = 32'(d.len); end
                        default: begin c.st = 2'b11; c.cyc = TIMEOUT; end
                    endcase
                end
                exp_q.push_back(c);
            end
            if (accept) begin
                d.tag = cmd_tag; d.op = cmd_operation; d.dt = cmd_data_type;
                d.m = cmd_m; d.n = cmd_n; d.k = cmd_k;
                d.kind = stim_kind; d.len = stim_len;
                mq.push_back(d);
            end
            if (flush) mq.delete();
            if (hs) in_flight = 0;
            if (pop) in_flight = 1;
            wd = in_flight ? wd + 1 : 0;
            if (wd > 2000) begin
                check("job_watchdog", 64'(wd), 64'(0));
                wd = 0;
            end
        end
    end

    // Completion monitor
    always @(negedge clk) begin
        cpl_t e;
        if (model_en && cpl_valid && cpl_ready) begin
            if (exp_q.size() == 0) begin
                check("cpl_unexpected", 64'(cpl_valid), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check("cpl_tag", 64'(cpl_tag), 64'(e.tag));
                check("cpl_status", 64'(cpl_status), 64'(e.st));
                check("cpl_cycles", 64'(cpl_cycles), 64'(e.cyc));
            end
        end
    end

    // Completion back-pressure driver
    initial begin
        cpl_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       cpl_ready = 1'b1;
                1:       cpl_ready = ($urandom_range(0, 99) < 60);
                default: cpl_ready = 1'b0;
            endcase
        end
    end

    task automatic set_cmd(input logic [TAG_W-1:0] tag, input logic [7:0] op, input logic [1:0] dt,
                           input logic [7:0] m, input logic [7:0] n, input logic [7:0] k,
                           input int kind, input int len);
        cmd_tag = tag; cmd_operation = op; cmd_data_type = dt;
        cmd_m = m; cmd_n = n; cmd_k = k;
        stim_kind = kind; stim_len = len;
    endtask

    task automatic send(input logic [TAG_W-1:0] tag, input logic [7:0] op, input logic [1:0] dt,
                        input logic [7:0] m, input logic [7:0] n, input logic [7:0] k,
                        input int kind, input int len);
        bit got = 0;
        @(posedge clk); #1;
        set_cmd(tag, op, dt, m, n, k, kind, len);
        cmd_valid = 1'b1;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            got = cmd_ready;
        end
        if (!got) check("send_accept_timeout", 64'(cmd_ready), 64'(1));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic rand_fields();
        logic [7:0] m, n, k;
        int r;
        m = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        n = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        k = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        r = $urandom_range(0, 3);
        set_cmd(TAG_W'(next_tag), 8'($urandom_range(0, 255)), 2'($urandom_range(0, 2)), m, n, k,
                (r < 2) ? 0 : r - 1, $urandom_range(1, 40));
        next_tag++;
    endtask

    initial begin
        bit acc;
        bit ok;
        rst_n = 1'b0; cmd_valid = 1'b0; flush = 1'b0;
        set_cmd('0, '0, '0, '0, '0, '0, 0, 1);
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        check("rst_queue_count", 64'(queue_count), 64'(0));
        check("rst_ctrl", {60'd0, tpu_enable, tpu_start, cpl_valid, 1'b0}, 64'd0);
        check("rst_cfg", {30'd0, tpu_operation, tpu_data_type, tpu_matrix_size_m, tpu_matrix_size_n,
                          tpu_matrix_size_k}, 64'd0);
        check("rst_cpl", {22'd0, cpl_tag, cpl_status, cpl_cycles}, 64'd0);
        #2 rst_n = 1'b1;
        model_en = 1;

        // Directed: normal job, rejected job, TPU error
        rdy_mode = 0;
        send(8'd5, 8'd1, 2'd0, 8'd4, 8'd4, 8'd4, 0, 20);
        send(8'd7, 8'd2, 2'd1, 8'd3, 8'd3, 8'd0, 0, 1);
        send(8'd9, 8'd3, 2'd2, 8'd2, 8'd5, 8'd6, 1, 6);

        // Back-pressure: completions held, FIFO fills, includes a timeout job
        rdy_mode = 2;
        fork
            begin
                for (int i = 0; i < DEPTH + 2; i++)
                    send(TAG_W'(100 + i), 8'(i), 2'd0, 8'd1, 8'd2, 8'd3, (i == 0) ? 2 : 0, 10 + i);
            end
            begin
                repeat (300) @(posedge clk);
                rdy_mode = 0;
            end
        join

        // Flush together with a new descriptor while a job is in flight
        repeat (400) @(posedge clk);
        rdy_mode = 2;
        for (int i = 0; i < 4; i++)
            send(TAG_W'(120 + i), 8'd7, 2'd1, 8'd8, 8'd8, 8'd8, 0, 30);
        @(posedge clk); #1;
        set_cmd(8'd130, 8'd9, 2'd0, 8'd1, 8'd1, 8'd1, 0, 5);
        cmd_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0; flush = 1'b0;
        rdy_mode = 0;

        // Randomised traffic with back-pressure phases and sporadic flush
        acc = 1;
        for (int cyc = 0; cyc < 2500; cyc++) begin
            @(posedge clk); #1;
            rdy_mode = ((cyc % 400) < 100) ? 2 : 1;
            if (!cmd_valid || acc) begin
                cmd_valid = ($urandom_range(0, 99) < 50);
                if (cmd_valid) rand_fields();
            end
            flush = ($urandom_range(0, 99) < 2);
            @(negedge clk);
            acc = cmd_valid && cmd_ready;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0; flush = 1'b0; rdy_mode = 0;

        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            ok = !in_flight && (mq.size() == 0) && (exp_q.size() == 0);
        end
        check("drain_exp_q", 64'(exp_q.size()), 64'(0));
        check("drain_queue_count", 64'(queue_count), 64'(0));

        // Reset in the middle of a running job
        send(8'd200, 8'd1, 2'd0, 8'd2, 8'd2, 8'd2, 2, 1);
        send(8'd201, 8'd1, 2'd0, 8'd2, 8'd2, 8'd2, 0, 5);
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = tpu_enable;
        end
        check("midjob_enable", 64'(tpu_enable), 64'(1));
        #2;
        model_en = 0;
        rst_n = 1'b0;
        #1;
        check("midrst_ctrl", {61'd0, tpu_enable, tpu_start, cpl_valid}, 64'd0);
        check("midrst_queue", {59'd0, cmd_ready, queue_count}, {59'd0, 1'b1, CW'(0)});
        check("midrst_cfg", {40'd0, tpu_matrix_size_m, tpu_matrix_size_n, tpu_matrix_size_k}, 64'd0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_no_cpl", 64'(cpl_valid), 64'(0));
        check("post_rst_no_enable", 64'(tpu_enable), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tpu_cmd_sequencer.md
Name: tpu_cmd_sequencer

Overview:
Upstream command front-end for the tpu accelerator. It queues matrix-operation descriptors from the host/CPU side and launches them one at a time on the TPU control interface (enable/start plus held configuration). It tracks each job to done, error or timeout, recovers the TPU from its error state, and returns one tagged completion record per descriptor.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, ≥2)
TAG_W, 8, width of descriptor tag
TIMEOUT, 32'd1000000, maximum RUN cycles before forced abort; 0 disables timeout

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  descriptor valid
cmd_ready  out  1  descriptor accepted when valid&ready
cmd_operation  in  8  operation code
cmd_data_type  in  2  00 INT8, 01 FP16, 10 FP32
cmd_m / cmd_n / cmd_k  in  8 each  matrix dimensions
cmd_tag  in  TAG_W  descriptor ID, returned in completion
flush  in  1  discard all queued (not in-flight) descriptors
tpu_enable  out  1  to TPU enable
tpu_start  out  1  to TPU start, one-cycle pulse
tpu_operation  out  8  held config
tpu_data_type  out  2  held config
tpu_matrix_size_m / _n / _k  out  8 each  held config
tpu_done  in  1  TPU done pulse
tpu_busy  in  1  TPU busy
tpu_error  in  1  TPU error
cpl_valid  out  1  completion valid
cpl_ready  in  1  completion accepted
cpl_tag  out  TAG_W  tag of completed descriptor
cpl_status  out  2  00 OK, 01 TPU error, 10 rejected, 11 timeout
cpl_cycles  out  32  cycles spent in RUN
queue_count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: FIFO empty, queue_count 0, state IDLE, all outputs 0 except cmd_ready=1.
- FIFO: push on cmd_valid&cmd_ready; cmd_ready = !full & !flush, with no bypass when full.
  - flush empties the FIFO next cycle. A push in the same cycle is not accepted, because ready is low.
  - Pop and push in the same cycle: count unchanged.
- FSM states: IDLE, LAUNCH, RUN, RECOVER, COMPLETE.
- IDLE: if FIFO non-empty & !tpu_busy, pop the head and register it.
  - If any of m/n/k == 0: go to COMPLETE with status 10 and cycles 0. The TPU is never started.
  - Otherwise: go to LAUNCH.
  - If flush arrives in the same cycle as the pop, the popped entry is still processed.
- LAUNCH (1 cycle): tpu_enable=1, tpu_start=1. Clear cycle counter. Go to RUN.
- RUN: tpu_enable=1, tpu_start=0. Cycle counter increments every cycle, saturating at 32'hFFFFFFFF.
  - tpu_done → COMPLETE, status 00.
  - else tpu_error → RECOVER, status 01 (done has priority if both are set).
  - else TIMEOUT≠0 & counter == TIMEOUT-1 → RECOVER, status 11.
  - cpl_cycles = number of RUN cycles including the exit cycle.
- RECOVER: tpu_enable=0. Stay at least 1 cycle. Exit to COMPLETE once tpu_busy==0 and tpu_error==0.
- COMPLETE: cpl_valid=1. cpl_tag, cpl_status and cpl_cycles stay stable until cpl_ready; on the handshake go to IDLE.
  - The next launch is therefore at least 1 cycle after acceptance.
- tpu_operation, tpu_data_type and tpu_matrix_size_* are registered at pop and stay unchanged until the next pop. They are 0 from reset until the first pop.
- tpu_enable is 0 in IDLE, RECOVER and COMPLETE; it is never high without a job in flight.
- flush does not affect the in-flight job or the completion register.
- Reset mid-job: everything returns to reset values immediately. No completion is produced for lost descriptors.
- Only one job is in flight; completions are returned in FIFO order.

Test Plan:
1. Push tag=5, op=1, m=n=k=4; TPU model asserts done 20 cycles after start.
   → exactly one tpu_start pulse with config 1/4/4/4; completion tag 5, status 00, cycles 20.
2. Push tag=7 with k=0.
   → no tpu_start; cpl_valid next cycle after pop, status 10, cycles 0.
3. Job runs; TPU asserts error at cycle 6 and holds busy until enable is low.
   → tpu_enable drops, sequencer waits for busy=0; completion status 01, cycles 6.
4. TIMEOUT=50 and TPU never asserts done.
   → RECOVER at RUN cycle 50; completion status 11, cycles 50.
5. Hold cpl_ready=0 and push DEPTH+2 descriptors.
   → cmd_ready drops when queue_count==DEPTH; second launch occurs only after cpl_ready; tags complete in order.
6. 3 descriptors queued, one in flight; assert flush together with a cmd_valid.
   → queue_count 0 next cycle, new descriptor not accepted; in-flight job still completes with its tag.
